// File: rtl/egress_reconfig_ctrl.sv
// Control-chain sequencer: ordinary writes pass straight through; egress-stage writes run hold/drain/write/settle.
// Optional feature macro EGRESS_RECONFIG_SHADOW_EN: keep a shadow of the egress word and skip repeat writes.
`ifndef CTRLWRD_SZ
`define CTRLWRD_SZ 12
`endif

module egress_reconfig_ctrl #(
  parameter int unsigned CTRL_STAGE     = 15,
  parameter int unsigned DRAIN_CYCLES   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                   Clk,
  input  logic                   ARst,
  input  logic [3:0]             HostAddr_i,
  input  logic [`CTRLWRD_SZ-1:0] HostWord_i,
  input  logic                   HostValid_i,
  output logic                   HostReady_o,
  output logic [3:0]             CtrlAddr_o,
  output logic [`CTRLWRD_SZ-1:0] CtrlWord_o,
  output logic                   CtrlValid_o,
  input  logic                   IngressValid_i,
  input  logic                   EgressValid_i,
  output logic                   IngressHold_o,
  output logic                   Busy_o,
  output logic                   Done_o,
  output logic                   TimeoutFlag_o,
  input  logic                   TimeoutClr_i,
  output logic [`CTRLWRD_SZ-1:0] ShadowWord_o
);

  localparam int unsigned   DW         = $clog2(DRAIN_CYCLES + 1);
  localparam int unsigned   TW         = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [3:0]    STAGE_ADDR = 4'(CTRL_STAGE);
  localparam logic [DW-1:0] DRAIN_MAX  = DW'(DRAIN_CYCLES);
  localparam logic [TW-1:0] TMO_MAX    = TW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PASS,
    ST_HOLD,
    ST_WRITE,
    ST_SETTLE
  } state_t;

  state_t                 state_q, state_d;
  logic [DW-1:0]          drain_q, drain_d, drain_inc;
  logic [TW-1:0]          tmo_q, tmo_d, tmo_inc;
  logic                   settle_q, settle_d;
  logic [`CTRLWRD_SZ-1:0] word_q, word_d;
  logic [3:0]             ctrl_addr_q, ctrl_addr_d;
  logic [`CTRLWRD_SZ-1:0] ctrl_word_q, ctrl_word_d;
  logic                   ctrl_valid_q, ctrl_valid_d;
  logic                   ready_q, busy_q, hold_q;
  logic                   done_q, done_d;
  logic                   tflag_q, tflag_d;
  logic                   shadow_hit;

`ifdef EGRESS_RECONFIG_SHADOW_EN
  logic [`CTRLWRD_SZ-1:0] shadow_q;

  always_ff @(posedge Clk or posedge ARst) begin
    if (ARst)                    shadow_q <= '0;
    else if (state_d == ST_WRITE) shadow_q <= word_q;
  end

  assign shadow_hit   = (HostWord_i == shadow_q);
  assign ShadowWord_o = shadow_q;
`else
  assign shadow_hit   = 1'b0;
  assign ShadowWord_o = '0;
`endif

  always_comb begin
    state_d      = state_q;
    drain_d      = drain_q;
    tmo_d        = tmo_q;
    settle_d     = settle_q;
    word_d       = word_q;
    ctrl_addr_d  = ctrl_addr_q;
    ctrl_word_d  = ctrl_word_q;
    ctrl_valid_d = 1'b0;
    done_d       = 1'b0;
    tflag_d      = TimeoutClr_i ? 1'b0 : tflag_q;
    // Both counters include the current HOLD cycle, so the exit decision uses the incremented values.
    drain_inc    = (IngressValid_i || EgressValid_i) ? '0 :
                   ((drain_q == DRAIN_MAX) ? drain_q : drain_q + DW'(1));
    tmo_inc      = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + TW'(1);

    case (state_q)
      ST_IDLE: begin
        if (HostValid_i) begin
          if (HostAddr_i != STAGE_ADDR) begin
            ctrl_addr_d  = HostAddr_i;
            ctrl_word_d  = HostWord_i;
            ctrl_valid_d = 1'b1;
            state_d      = ST_PASS;
          end else if (shadow_hit) begin
            done_d = 1'b1;
          end else begin
            word_d  = HostWord_i;
            drain_d = '0;
            tmo_d   = '0;
            state_d = ST_HOLD;
          end
        end
      end
      ST_PASS: state_d = ST_IDLE;
      ST_HOLD: begin
        drain_d = drain_inc;
        tmo_d   = tmo_inc;
        if (drain_inc == DRAIN_MAX || tmo_inc == TMO_MAX) begin
          ctrl_addr_d  = STAGE_ADDR;
          ctrl_word_d  = word_q;
          ctrl_valid_d = 1'b1;
          state_d      = ST_WRITE;
          // A drain that completes on the timeout cycle is not a timeout.
          if (drain_inc != DRAIN_MAX) tflag_d = 1'b1;
        end
      end
      ST_WRITE: begin
        settle_d = 1'b0;
        state_d  = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_q) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          settle_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge ARst) begin
    if (ARst) begin
      state_q      <= ST_IDLE;
      drain_q      <= '0;
      tmo_q        <= '0;
      settle_q     <= 1'b0;
      word_q       <= '0;
      ctrl_addr_q  <= '0;
      ctrl_word_q  <= '0;
      ctrl_valid_q <= 1'b0;
      ready_q      <= 1'b1;
      busy_q       <= 1'b0;
      hold_q       <= 1'b0;
      done_q       <= 1'b0;
      tflag_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      drain_q      <= drain_d;
      tmo_q        <= tmo_d;
      settle_q     <= settle_d;
      word_q       <= word_d;
      ctrl_addr_q  <= ctrl_addr_d;
      ctrl_word_q  <= ctrl_word_d;
      ctrl_valid_q <= ctrl_valid_d;
      ready_q      <= (state_d == ST_IDLE);
      busy_q       <= (state_d != ST_IDLE);
      hold_q       <= (state_d == ST_HOLD) || (state_d == ST_WRITE) || (state_d == ST_SETTLE);
      done_q       <= done_d;
      tflag_q      <= tflag_d;
    end
  end

  assign HostReady_o   = ready_q;
  assign CtrlAddr_o    = ctrl_addr_q;
  assign CtrlWord_o    = ctrl_word_q;
  assign CtrlValid_o   = ctrl_valid_q;
  assign IngressHold_o = hold_q;
  assign Busy_o        = busy_q;
  assign Done_o        = done_q;
  assign TimeoutFlag_o = tflag_q;

endmodule
